// File: rtl/data_ram_lat.sv
// data_ram_lat: latency-configurable LSU data RAM model with range checking; rev 1.0
// Optional DATA_RAM_STALL_INJECT_EN adds 0..3 LFSR-driven wait cycles per access.
`default_nettype none

module data_ram_lat #(
  parameter int          WIDTH      = 32,
  parameter int          DEPTH      = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          RD_LATENCY = 1,
  parameter int          WR_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          data_addr_i,
  input  logic [WIDTH-1:0]     store_data_i,
  input  logic                 MemR_en_i,
  input  logic                 MemW_en_i,
  input  logic [WIDTH/8-1:0]   byte_enable_i,
  output logic [WIDTH-1:0]     load_data_o,
  output logic                 read_valid_o,
  output logic                 write_ready_o,
  output logic                 access_err_o,
  input  logic [WIDTH-1:0]     data_mem_i [DEPTH]
);

  localparam int          NB         = WIDTH / 8;
  localparam int          OFFS       = (NB > 1) ? $clog2(NB) : 0;
  localparam int          IDXW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] ALIGN_MASK = 32'(NB - 1);
  localparam logic [3:0]  RD_CNT     = 4'(RD_LATENCY - 1);
  localparam logic [3:0]  WR_CNT     = 4'(WR_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [NB-1:0]     be_q;
  logic              oor_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic [31:0]       off_d;
  logic [31:0]       widx_d;
  logic              oor_d;
  logic              stall_d;

  // Underflow of the subtraction is caught by the explicit addr<BASE term.
  always_comb begin
    off_d  = data_addr_i - BASE_ADDR;
    widx_d = off_d >> OFFS;
    oor_d  = (data_addr_i < BASE_ADDR) || ((off_d & ALIGN_MASK) != 32'd0) ||
             (widx_d >= 32'(DEPTH));
  end

`ifdef DATA_RAM_STALL_INJECT_EN
  logic [7:0] lfsr_q;
  logic [1:0] stall_n_q;

  always_comb begin
    stall_d = (lfsr_q[1:0] == 2'b00) && (stall_n_q != 2'd3);
  end

  // x^8+x^6+x^5+x^4+1; stall counter bounds consecutive deferrals to three.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q    <= 8'hA5;
      stall_n_q <= 2'd0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (state_q == IDLE) begin
        stall_n_q <= 2'd0;
      end else if ((state_q == RD_WAIT || state_q == WR_WAIT) && cnt_q == 4'd0 && stall_d) begin
        stall_n_q <= stall_n_q + 2'd1;
      end
    end
  end
`else
  always_comb begin
    stall_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      idx_q         <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      oor_q         <= 1'b0;
      load_data_o   <= '0;
      read_valid_o  <= 1'b0;
      write_ready_o <= 1'b0;
      access_err_o  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= data_mem_i[i];
      end
    end else begin
      read_valid_o  <= 1'b0;
      write_ready_o <= 1'b0;
      access_err_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MemW_en_i || MemR_en_i) begin
            idx_q   <= widx_d[IDXW-1:0];
            wdata_q <= store_data_i;
            be_q    <= byte_enable_i;
            oor_q   <= oor_d;
          end
          // A simultaneous read is dropped in favour of the write.
          if (MemW_en_i) begin
            state_q      <= WR_WAIT;
            cnt_q        <= WR_CNT;
            access_err_o <= MemR_en_i;
          end else if (MemR_en_i) begin
            state_q <= RD_WAIT;
            cnt_q   <= RD_CNT;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (!stall_d) begin
            state_q      <= DONE;
            access_err_o <= oor_q;
            if (state_q == RD_WAIT) begin
              read_valid_o <= 1'b1;
              load_data_o  <= oor_q ? '0 : mem[idx_q];
            end else begin
              write_ready_o <= 1'b1;
              for (int b = 0; b < NB; b++) begin
                if (be_q[b] && !oor_q) begin
                  mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
              end
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
